// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit: condition codes,
// 2-bit bimodal counter type/states and the saturating counter update.
package bru_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BLTZ = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLEZ = 3'b011;
    localparam logic [2:0] BR_BGTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t CNT_SNT   = 2'b00;
    localparam bht_cnt_t CNT_WNT   = 2'b01;
    localparam bht_cnt_t CNT_WT    = 2'b10;
    localparam bht_cnt_t CNT_ST    = 2'b11;
    localparam bht_cnt_t CNT_RESET = CNT_WNT;

    function automatic bht_cnt_t cnt_next(input bht_cnt_t c, input logic taken);
        if (taken)
            return (c == CNT_ST) ? CNT_ST : bht_cnt_t'(c + 2'd1);
        else
            return (c == CNT_SNT) ? CNT_SNT : bht_cnt_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bru_cond.sv
// Combinational branch condition evaluator; all compares are signed on a.
// Unassigned condition codes resolve not-taken.
module bru_cond
    import bru_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              taken
);

    logic a_neg;
    logic a_zero;

    assign a_neg  = a[DATA_W-1];
    assign a_zero = (a == '0);

    always_comb begin
        taken = 1'b0;
        case (op)
            BR_BEQ:  taken = (a == b);
            BR_BLTZ: taken = a_neg;
            BR_BNE:  taken = (a != b);
            BR_BLEZ: taken = a_neg | a_zero;
            BR_BGTZ: taken = ~a_neg & ~a_zero;
            BR_BGEZ: taken = ~a_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution with a bimodal BHT predictor and registered mispredict flush.
// Define BRU_STATS_EN to build the saturating branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              rs_valid,
    input  logic [PC_W-1:0]   rs_pc,
    input  logic [2:0]        rs_op,
    input  logic [DATA_W-1:0] rs_a,
    input  logic [DATA_W-1:0] rs_b,
    input  logic              rs_pred_taken,
    input  logic [PC_W-1:0]   rs_target,
    input  logic [PC_W-1:0]   rs_fallthrough,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bht_cnt_t [BHT_DEPTH-1:0] bht;
    logic [IDX_W-1:0]         if_idx;
    logic [IDX_W-1:0]         rs_idx;
    logic                     taken;
    logic                     upd;
    logic                     mispred;
    logic                     unused_pc;

    assign if_idx    = if_pc[IDX_LSB +: IDX_W];
    assign rs_idx    = rs_pc[IDX_LSB +: IDX_W];
    assign unused_pc = ^{if_pc, rs_pc};

    bru_cond #(.DATA_W(DATA_W)) u_cond (
        .op    (rs_op),
        .a     (rs_a),
        .b     (rs_b),
        .taken (taken)
    );

    // The resolving instruction behind a flush is wrong-path: drop it entirely.
    assign upd     = rs_valid & ~flush;
    assign mispred = upd & (taken != rs_pred_taken);

    // Read sees the array before this edge's write, so collisions return old state.
    assign pred_taken = bht[if_idx][1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= CNT_RESET;
        end else if (upd) begin
            bht[rs_idx] <= cnt_next(bht[rs_idx], taken);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispred;
            if (mispred)
                redirect_pc <= taken ? rs_target : rs_fallthrough;
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] br_q;
    logic [31:0] mp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            if (upd && br_q != 32'hFFFF_FFFF)
                br_q <= br_q + 32'd1;
            if (mispred && mp_q != 32'hFFFF_FFFF)
                mp_q <= mp_q + 32'd1;
        end
    end

    assign branch_cnt     = br_q;
    assign mispredict_cnt = mp_q;
`else
    assign branch_cnt     = 32'd0;
    assign mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: reset, training, mispredict, squash,
// read/write collision, boundary condition codes and asynchronous reset.
module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic        rs_valid = 1'b0;
    logic [31:0] rs_pc = '0;
    logic [2:0]  rs_op = '0;
    logic [31:0] rs_a = '0;
    logic [31:0] rs_b = '0;
    logic        rs_pred_taken = 1'b0;
    logic [31:0] rs_target = '0;
    logic [31:0] rs_fallthrough = '0;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int tests = 0;
    int fails = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_resolve_unit #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(64), .IDX_LSB(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .rs_valid       (rs_valid),
        .rs_pc          (rs_pc),
        .rs_op          (rs_op),
        .rs_a           (rs_a),
        .rs_b           (rs_b),
        .rs_pred_taken  (rs_pred_taken),
        .rs_target      (rs_target),
        .rs_fallthrough (rs_fallthrough),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Present a resolving branch at the falling edge.
    task automatic drive(input logic [31:0] pc, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic pr, input logic [31:0] tgt,
                         input logic [31:0] ft);
        @(negedge clk);
        rs_valid = 1'b1; rs_pc = pc; rs_op = op; rs_a = a; rs_b = b;
        rs_pred_taken = pr; rs_target = tgt; rs_fallthrough = ft;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        rs_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stats(input string name);
        logic [31:0] eb, em;
        eb = STATS ? 32'(exp_br) : 32'd0;
        em = STATS ? 32'(exp_mp) : 32'd0;
        tests++;
        if (branch_cnt !== eb) begin fails++; $display("FAIL %s branch_cnt got %0d exp %0d", name, branch_cnt, eb); end
        tests++;
        if (mispredict_cnt !== em) begin fails++; $display("FAIL %s mispredict_cnt got %0d exp %0d", name, mispredict_cnt, em); end
    endtask

    task automatic test_reset();
        tests++;
        if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush); end
        tests++;
        if (redirect_pc !== 32'h0) begin fails++; $display("FAIL reset_redirect got %h exp 0", redirect_pc); end
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            tests++;
            if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred idx %0d got %b exp 0", i, pred_taken); end
        end
        test_stats("reset");
    endtask

    task automatic test_train();
        if_pc = 32'h40;
        // First update: entry 01 predicts NT, branch taken -> mispredict.
        drive(32'h40, 3'b000, 32'd5, 32'd5, 1'b0, 32'h200, 32'h44);
        tests++;
        if (pred_taken !== 1'b0) begin fails++; $display("FAIL train_pred0 got %b exp 0", pred_taken); end
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h200) begin
            fails++; $display("FAIL train_flush1 got %b/%h exp 1/00000200", flush, redirect_pc);
        end
        tests++;
        if (pred_taken !== 1'b1) begin fails++; $display("FAIL train_pred1 got %b exp 1", pred_taken); end
        idle();
        tests++;
        if (flush !== 1'b0) begin fails++; $display("FAIL train_flush_width got %b exp 0", flush); end
        for (int k = 0; k < 2; k++) begin
            drive(32'h40, 3'b000, 32'd5, 32'd5, 1'b1, 32'h200, 32'h44);
            @(posedge clk); #1;
            exp_br++;
            tests++;
            if (flush !== 1'b0 || pred_taken !== 1'b1) begin
                fails++; $display("FAIL train_upd%0d flush/pred got %b/%b exp 0/1", k + 2, flush, pred_taken);
            end
        end
        idle();
        tests++;
        if (redirect_pc !== 32'h200) begin fails++; $display("FAIL train_redirect_hold got %h exp 00000200", redirect_pc); end
        // Entry should now be 11: one NT outcome still leaves it predicting taken.
        drive(32'h40, 3'b010, 32'd5, 32'd5, 1'b1, 32'h200, 32'h44);
        @(posedge clk); #1;
        exp_br++;
        tests++;
        if (pred_taken !== 1'b1 || flush !== 1'b1) begin
            fails++; $display("FAIL train_saturate pred/flush got %b/%b exp 1/1", pred_taken, flush);
        end
        exp_mp++;
        idle();
        test_stats("train");
    endtask

    task automatic test_mispredict();
        drive(32'hC0, 3'b001, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h100, 32'hC4);
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h100) begin
            fails++; $display("FAIL mispredict got %b/%h exp 1/00000100", flush, redirect_pc);
        end
        test_stats("mispredict");
        idle();
        tests++;
        if (flush !== 1'b0 || redirect_pc !== 32'h100) begin
            fails++; $display("FAIL mispredict_pulse got %b/%h exp 0/00000100", flush, redirect_pc);
        end
    endtask

    task automatic test_squash();
        if_pc = 32'h100;
        drive(32'h100, 3'b010, 32'd1, 32'd2, 1'b0, 32'h300, 32'h104);
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h300) begin
            fails++; $display("FAIL squash_flush got %b/%h exp 1/00000300", flush, redirect_pc);
        end
        @(posedge clk); #1;
        tests++;
        if (flush !== 1'b0) begin fails++; $display("FAIL squash_single_pulse got %b exp 0", flush); end
        test_stats("squash");
        // One update leaves the entry at 10; a NT outcome must drop it to 01.
        drive(32'h100, 3'b010, 32'd3, 32'd3, 1'b1, 32'h300, 32'h104);
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (pred_taken !== 1'b0) begin fails++; $display("FAIL squash_one_update pred got %b exp 0", pred_taken); end
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h104) begin
            fails++; $display("FAIL squash_fallthrough got %b/%h exp 1/00000104", flush, redirect_pc);
        end
        idle();
    endtask

    task automatic test_collision();
        if_pc = 32'h80;
        drive(32'h80, 3'b000, 32'd9, 32'd9, 1'b0, 32'h400, 32'h84);
        tests++;
        if (pred_taken !== 1'b0) begin fails++; $display("FAIL collision_same_cycle got %b exp 0", pred_taken); end
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (pred_taken !== 1'b1) begin fails++; $display("FAIL collision_next_cycle got %b exp 1", pred_taken); end
        idle();
    endtask

    task automatic test_boundary_ops();
        if_pc = 32'h10;
        drive(32'h10, 3'b011, 32'd0, 32'd7, 1'b1, 32'h500, 32'h14);
        @(posedge clk); #1;
        exp_br++;
        tests++;
        if (flush !== 1'b0 || pred_taken !== 1'b1) begin
            fails++; $display("FAIL blez_zero flush/pred got %b/%b exp 0/1", flush, pred_taken);
        end
        drive(32'h14, 3'b100, 32'd0, 32'd7, 1'b1, 32'h600, 32'h18);
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h18) begin
            fails++; $display("FAIL bgtz_zero got %b/%h exp 1/00000018", flush, redirect_pc);
        end
        idle();
        drive(32'h20, 3'b111, 32'd0, 32'd0, 1'b1, 32'h700, 32'h24);
        @(posedge clk); #1;
        exp_br++; exp_mp++;
        tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h24) begin
            fails++; $display("FAIL op111 got %b/%h exp 1/00000024", flush, redirect_pc);
        end
        idle();
        test_stats("boundary");
    endtask

    task automatic test_async_reset();
        if_pc = 32'h40;
        drive(32'h28, 3'b101, 32'd0, 32'd0, 1'b0, 32'h800, 32'h2C);
        @(posedge clk); #1;
        tests++;
        if (flush !== 1'b1) begin fails++; $display("FAIL areset_setup got %b exp 1", flush); end
        rs_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        exp_br = 0; exp_mp = 0;
        tests++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
            fails++; $display("FAIL areset_flush got %b/%h exp 0/00000000", flush, redirect_pc);
        end
        tests++;
        if (pred_taken !== 1'b0) begin fails++; $display("FAIL areset_bht got %b exp 0", pred_taken); end
        test_stats("areset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_train();
        test_mispredict();
        test_squash();
        test_collision();
        test_boundary_ops();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
